// File: rtl/serial_subtractor_8bit.sv
// rtl/serial_subtractor_8bit.sv - bit-serial 8-bit subtractor, LSB first, with borrow/overflow/zero flags
module serial_subtractor_8bit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] A,
   input  logic [7:0] B,
   output logic [7:0] Diff,
   output logic       Bout,
   output logic       Ovf,
   output logic       Zero,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] a_sr;
   logic [7:0] b_sr;
   logic [7:0] r_sr;
   logic       bw;
   logic [2:0] cnt;
   logic       a_msb;
   logic       b_msb;

   // one full-subtractor slice on the current LSBs
   logic       d_bit;
   logic       bw_next;
   logic [7:0] r_next;

   // combinational bit slice and the result word including this bit
   always_comb begin
      d_bit   = a_sr[0] ^ b_sr[0] ^ bw;
      bw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bw);
      r_next  = {d_bit, r_sr[7:1]};
   end

   // control FSM, datapath shift registers and registered result flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= 8'h00;
         b_sr  <= 8'h00;
         r_sr  <= 8'h00;
         bw    <= 1'b0;
         cnt   <= 3'd0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         Diff  <= 8'h00;
         Bout  <= 1'b0;
         Ovf   <= 1'b0;
         Zero  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  a_msb <= A[7];
                  b_msb <= B[7];
                  r_sr  <= 8'h00;
                  bw    <= 1'b0;
                  cnt   <= 3'd0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sr <= {1'b0, a_sr[7:1]};
               b_sr <= {1'b0, b_sr[7:1]};
               r_sr <= r_next;
               bw   <= bw_next;
               cnt  <= cnt + 3'd1;
               // bit 7 ends the run; the 3-bit counter never wraps into a 9th bit
               if (cnt == 3'd7) begin
                  Diff  <= r_next;
                  Bout  <= bw_next;
                  Ovf   <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
                  Zero  <= (r_next == 8'h00);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               // the exit edge of DONE doubles as the IDLE sampling edge so a
               // held start sustains one result every 9 cycles
               done <= 1'b0;
               if (start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  a_msb <= A[7];
                  b_msb <= B[7];
                  r_sr  <= 8'h00;
                  bw    <= 1'b0;
                  cnt   <= 3'd0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// tb/tb_serial_subtractor_8bit.sv - directed self-checking bench for serial_subtractor_8bit
module tb_serial_subtractor_8bit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] Diff;
   logic       Bout;
   logic       Ovf;
   logic       Zero;
   logic       busy;
   logic       done;

   int compared;
   int mismatched;

   serial_subtractor_8bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .Diff  (Diff),
      .Bout  (Bout),
      .Ovf   (Ovf),
      .Zero  (Zero),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // launch one operation; optionally poke start/A/B mid-run, which must be ignored
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input logic ez, input bit perturb);
      int n;
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      chk({tag, ".busy_run"}, busy, 1'b1);
      chk({tag, ".done_run"}, done, 1'b0);
      while (!done && n < 20) begin
         if (perturb) begin
            case (n)
               3: begin start = 1'b1; A = 8'hFF; B = 8'h00; end
               4: start = 1'b0;
               8: start = 1'b1;
               default: ;
            endcase
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk({tag, ".latency"}, n, 9);
      chk({tag, ".done"}, done, 1'b1);
      chk({tag, ".busy_done"}, busy, 1'b0);
      chk({tag, ".diff"}, Diff, ed);
      chk({tag, ".bout"}, Bout, eb);
      chk({tag, ".ovf"}, Ovf, eo);
      chk({tag, ".zero"}, Zero, ez);
      @(negedge clk);
      chk({tag, ".done_gone"}, done, 1'b0);
      chk({tag, ".diff_hold"}, Diff, ed);
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      int done_pos [3];
      int dsum;
      compared   = 0;
      mismatched = 0;
      rst_n = 1'b0;
      start = 1'b0;
      A = 8'h00;
      B = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset.diff", Diff, 8'h00);
      chk("reset.flags", {Bout, Ovf, Zero, busy, done}, 5'b00000);
      rst_n = 1'b1;

      run_op("op05m03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("op03m05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op("op80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op("op7Fm FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
      run_op("opA5mA5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

      // nothing queued by the mid-run start pulses
      dsum = 0;
      repeat (4) begin
         @(negedge clk);
         dsum += int'(done) + int'(busy);
      end
      chk("ignored.no_second", dsum, 0);
      chk("ignored.zero_hold", Zero, 1'b1);

      // held start: one result every 9 cycles, busy 8 of 9
      A = 8'h10;
      B = 8'h01;
      start = 1'b1;
      busy_cnt = 0;
      done_cnt = 0;
      dsum = 0;
      for (int i = 0; i < 27; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            if (done_cnt < 3) done_pos[done_cnt] = i;
            done_cnt++;
         end
         if (busy && done) dsum++;
      end
      start = 1'b0;
      chk("b2b.done_cnt", done_cnt, 3);
      chk("b2b.busy_cnt", busy_cnt, 24);
      chk("b2b.overlap", dsum, 0);
      if (done_cnt >= 3) begin
         chk("b2b.first", done_pos[0], 8);
         chk("b2b.period1", done_pos[1] - done_pos[0], 9);
         chk("b2b.period2", done_pos[2] - done_pos[1], 9);
      end
      chk("b2b.diff", Diff, 8'h0F);
      repeat (3) @(negedge clk);

      // abort in RUN cycle 4 via asynchronous reset
      A = 8'h05;
      B = 8'h03;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort.busy_before", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort.diff", Diff, 8'h00);
      chk("abort.flags", {Bout, Ovf, Zero, busy, done}, 5'b00000);
      @(negedge clk);
      rst_n = 1'b1;
      dsum = 0;
      repeat (12) begin
         @(negedge clk);
         dsum += int'(done);
      end
      chk("abort.no_done", dsum, 0);
      run_op("op10m01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
